cpu_bus_responder: RTL and testbench

//  Memory-side responder for the 2A03 CPU bus driven by control: decodes each CPU request to internal RAM,
//  PRG ROM, PPU registers or open bus and returns read data/ack one cycle later. Also implements the
//  $4014 OAM DMA engine, which halts the CPU via cpu_rdy and copies one 256-byte page to PPU $2004.

---
 rtl/cpu_bus_responder.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// ============================================================================
// Module : cpu_bus_responder
// Brief  : 2A03 CPU bus responder: decodes RAM/PPU/ROM/open bus, acks each
//          request one cycle later, and runs the $4014 OAM DMA engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_bus_responder #(
    parameter int unsigned RAM_AW   = 11,
    parameter int unsigned ROM_AW   = 15,
    parameter logic [15:0] DMA_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_REG  = 3'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    input  logic              mem_rw_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_rdata_o,
    output logic              cpu_rdy_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_rdata_i,
    output logic [2:0]        ppu_addr_o,
    output logic              ppu_we_o,
    output logic              ppu_re_o,
    output logic [7:0]        ppu_wdata_o,
    input  logic [7:0]        ppu_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESP  = 3'd1,
        S_ALIGN = 3'd2,
        S_DRD   = 3'd3,
        S_DWR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_PPU  = 2'd1,
        SEL_ROM  = 2'd2,
        SEL_OPEN = 2'd3
    } sel_t;

    state_t      state_q, state_d;
    sel_t        sel_q, sel_d, w_sel;
    logic        rd_q, rd_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        dma_q, dma_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic        parity_q;
    logic        rdy_q, rdy_d;

    logic        w_accept;
    logic        w_access;
    logic        w_is_rd;
    logic [15:0] w_addr;
    logic [7:0]  w_rd_byte;

    // The DMA start cycle (RESP of a $4014 write) refuses new requests.
    assign w_accept = cpu_req_i && !rst &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) ||
                       ((state_q == S_RESP) && !dma_q));
    assign w_access = w_accept || ((state_q == S_DRD) && !rst);
    assign w_is_rd  = (state_q == S_DRD) ? 1'b1 : mem_rw_i;
    assign w_addr   = (state_q == S_DRD) ? {page_q, idx_q} : cpu_addr_i;

    always_comb begin
        w_sel = SEL_OPEN;
        if (w_addr[15:13] == 3'b000)      w_sel = SEL_RAM;
        else if (w_addr[15:13] == 3'b001) w_sel = SEL_PPU;
        else if (w_addr[15])              w_sel = SEL_ROM;
    end

    always_comb begin
        case (sel_q)
            SEL_RAM: w_rd_byte = ram_rdata_i;
            SEL_PPU: w_rd_byte = ppu_rdata_i;
            SEL_ROM: w_rd_byte = rom_rdata_i;
            default: w_rd_byte = open_bus_q;
        endcase
    end

    assign cpu_ack_o   = (state_q == S_RESP);
    assign cpu_rdata_o = (cpu_ack_o && rd_q) ? w_rd_byte : 8'h00;
    assign cpu_rdy_o   = rdy_q;

    always_comb begin
        ram_addr_o  = w_addr[RAM_AW-1:0];
        ram_wdata_o = cpu_wdata_i;
        rom_addr_o  = w_addr[ROM_AW-1:0];
        ram_we_o    = w_access && !w_is_rd && (w_sel == SEL_RAM);
        ppu_re_o    = w_access &&  w_is_rd && (w_sel == SEL_PPU);
        ppu_we_o    = w_access && !w_is_rd && (w_sel == SEL_PPU);
        ppu_addr_o  = w_addr[2:0];
        ppu_wdata_o = cpu_wdata_i;
        if (state_q == S_DWR) begin
            ppu_we_o    = !rst;
            ppu_addr_o  = OAM_REG;
            ppu_wdata_o = w_rd_byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        dma_d      = 1'b0;
        page_d     = page_q;
        idx_d      = idx_q;
        open_bus_d = open_bus_q;
        rdy_d      = rdy_q;

        if (w_accept) begin
            sel_d   = w_sel;
            rd_d    = mem_rw_i;
            wdata_d = cpu_wdata_i;
            dma_d   = !mem_rw_i && (cpu_addr_i == DMA_ADDR);
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_RESP;
            end
            S_RESP: begin
                open_bus_d = rd_q ? w_rd_byte : wdata_q;
                if (dma_q) begin
                    state_d = S_ALIGN;
                    page_d  = wdata_q;
                    rdy_d   = 1'b0;
                end else if (w_accept) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALIGN: begin
                // Parity alternates, so an odd entry costs exactly one extra cycle.
                if (!parity_q) begin
                    state_d = S_DRD;
                    idx_d   = 8'h00;
                end
            end
            S_DRD: begin
                sel_d   = w_sel;
                state_d = S_DWR;
            end
            S_DWR: begin
                open_bus_d = w_rd_byte;
                idx_d      = idx_q + 8'h01;
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = S_DRD;
                end
            end
            S_DONE: begin
                state_d = w_accept ? S_RESP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= SEL_OPEN;
            rd_q       <= 1'b0;
            wdata_q    <= 8'h00;
            dma_q      <= 1'b0;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            open_bus_q <= 8'h00;
            parity_q   <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            dma_q      <= dma_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            open_bus_q <= open_bus_d;
            parity_q   <= ~parity_q;
            rdy_q      <= rdy_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
// ============================================================================
// Module : tb_cpu_bus_responder
// Brief  : Randomized and directed bench for cpu_bus_responder with a
//          behavioural bus/DMA reference model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        mem_rw;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [14:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [2:0]  ppu_addr;
    logic        ppu_we;
    logic        ppu_re;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;

    always #5 clk = ~clk;

    cpu_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .mem_rw_i    (mem_rw),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .cpu_rdy_o   (cpu_rdy),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata),
        .ppu_addr_o  (ppu_addr),
        .ppu_we_o    (ppu_we),
        .ppu_re_o    (ppu_re),
        .ppu_wdata_o (ppu_wdata),
        .ppu_rdata_i (ppu_rdata)
    );

    // Target devices with one-cycle synchronous reads
    logic [7:0] dev_ram [0:2047];
    logic [7:0] dev_rom [0:32767];
    logic [7:0] dev_ppu [0:7];

    always @(posedge clk) begin
        if (ram_we) dev_ram[ram_addr] <= ram_wdata;
        ram_rdata <= dev_ram[ram_addr];
        rom_rdata <= dev_rom[rom_addr];
        if (ppu_we) dev_ppu[ppu_addr] <= ppu_wdata;
        ppu_rdata <= dev_ppu[ppu_addr];
    end

    int          n_ram_we = 0;
    int          n_ppu_we = 0;
    int          n_ppu_re = 0;
    int          cyc      = 0;
    logic [10:0] ppu_wq [$];

    always @(posedge clk) begin
        if (ram_we) n_ram_we <= n_ram_we + 1;
        if (ppu_re) n_ppu_re <= n_ppu_re + 1;
        if (ppu_we) begin
            n_ppu_we <= n_ppu_we + 1;
            ppu_wq.push_back({ppu_addr, ppu_wdata});
        end
        cyc <= rst ? 0 : cyc + 1;
    end

    // Reference model state
    logic [7:0] ref_ram [0:2047];
    logic [7:0] ref_ppu [0:7];
    logic [7:0] ref_ob;
    int         exp_ram_we = 0;
    int         exp_ppu_we = 0;
    int         exp_ppu_re = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_peek(input logic [15:0] a);
        if (a < 16'h2000)       return ref_ram[int'(a) % 2048];
        else if (a < 16'h4000)  return ref_ppu[int'(a) % 8];
        else if (a >= 16'h8000) return dev_rom[int'(a) - 32768];
        else                    return ref_ob;
    endfunction

    task automatic model_op(input logic rw, input logic [15:0] a, input logic [7:0] d,
                            output logic [7:0] e);
        e = 8'h00;
        if (rw) begin
            e      = model_peek(a);
            ref_ob = e;
            if (a >= 16'h2000 && a < 16'h4000) exp_ppu_re++;
        end else begin
            ref_ob = d;
            if (a < 16'h2000) begin
                ref_ram[int'(a) % 2048] = d;
                exp_ram_we++;
            end else if (a < 16'h4000) begin
                ref_ppu[int'(a) % 8] = d;
                exp_ppu_we++;
            end
        end
    endtask

    logic       pend = 1'b0;
    logic       pend_rd;
    logic [7:0] pend_data;

    task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] d);
        logic [7:0] e;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        mem_rw    = rw;
        model_op(rw, a, d, e);
        pend      = 1'b1;
        pend_rd   = rw;
        pend_data = e;
    endtask

    task automatic step();
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check_value("ack", 32'(cpu_ack), 32'(pend));
        if (pend && pend_rd) check_value("rdata", 32'(cpu_rdata), 32'(pend_data));
        pend = 1'b0;
    endtask

    task automatic run_dma(input logic [7:0] page, input logic want_odd, input int exp_len);
        logic [7:0] exp_q [$];
        int low, ign_ack, we0, nchk;
        low = 0; ign_ack = 0;
        for (int g = 0; g < 4 && (cyc[0] != want_odd); g++) step();
        issue(1'b0, 16'h4014, page);
        for (int k = 0; k < 256; k++) begin
            exp_q.push_back(model_peek({page, 8'(k)}));
            ref_ob = exp_q[k];
        end
        step();
        ppu_wq.delete();
        we0       = n_ram_we;
        cpu_req   = 1'b1;
        cpu_addr  = 16'h0300;
        cpu_wdata = 8'hEE;
        mem_rw    = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            if (cpu_ack) ign_ack++;
            if (cpu_rdy) break;
            low++;
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 16'h1FFF));
            mem_rw    = 1'($urandom_range(0, 1));
            cpu_wdata = 8'($urandom);
        end
        check_value("dma_len", 32'(low), 32'(exp_len));
        check_value("dma_ack", 32'(ign_ack), 32'd0);
        check_value("dma_ram_we", 32'(n_ram_we - we0), 32'd0);
        check_value("dma_cnt", 32'(ppu_wq.size()), 32'd256);
        nchk = (ppu_wq.size() < 256) ? ppu_wq.size() : 256;
        for (int k = 0; k < nchk; k++)
            check_value("dma_wr", 32'(ppu_wq[k]), {21'd0, 3'd4, exp_q[k]});
        ref_ppu[4] = exp_q[255];
        exp_ppu_we += 256;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic        rw;
        int          we0, waited;
        logic [7:0]  keep4;

        for (int k = 0; k < 2048; k++) begin
            dev_ram[k] = 8'($urandom);
            ref_ram[k] = dev_ram[k];
        end
        for (int k = 0; k < 32768; k++) dev_rom[k] = 8'($urandom);
        dev_rom[32'h7FFC] = 8'h34;
        for (int k = 0; k < 8; k++) begin
            dev_ppu[k] = 8'($urandom);
            ref_ppu[k] = dev_ppu[k];
        end
        ref_ob = 8'h00;

        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0; mem_rw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ack", 32'(cpu_ack), 32'd0);
        check_value("rst_rdata", 32'(cpu_rdata), 32'd0);
        check_value("rst_rdy", 32'(cpu_rdy), 32'd1);
        check_value("rst_strobes", {29'd0, ram_we, ppu_we, ppu_re}, 32'd0);
        rst = 1'b0;
        step();

        // Write then mirrored read
        we0 = n_ram_we;
        issue(1'b0, 16'h0005, 8'hA5);
        step();
        check_value("t1_ram_we", 32'(n_ram_we - we0), 32'd1);
        issue(1'b1, 16'h0805, 8'h00);
        step();
        check_value("t1_mirror", 32'(cpu_rdata), 32'hA5);

        // ROM read and ignored ROM write
        issue(1'b1, 16'hFFFC, 8'h00);
        #1;
        check_value("t2_rom_addr", 32'(rom_addr), 32'h7FFC);
        step();
        issue(1'b0, 16'h8000, 8'h55);
        step();
        issue(1'b1, 16'h8000, 8'h00);
        step();

        // Back-to-back reads
        issue(1'b1, 16'h0000, 8'h00);
        step();
        issue(1'b1, 16'h0001, 8'h00);
        step();
        step();

        // Open bus
        issue(1'b0, 16'h0010, 8'h7E);
        step();
        issue(1'b1, 16'h0010, 8'h00);
        step();
        issue(1'b1, 16'h5000, 8'h00);
        step();
        check_value("t4_open_bus", 32'(cpu_rdata), 32'h7E);
        issue(1'b0, 16'h4016, 8'h99);
        step();
        issue(1'b1, 16'h6123, 8'h00);
        step();

        // Randomized traffic, back-to-back or with idle gaps
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
                2:       a = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: a = 16'($urandom_range(16'h4000, 16'h7FFF));
            endcase
            if (!rw && a == 16'h4014) a = 16'h4015;
            issue(rw, a, 8'($urandom));
            step();
            repeat ($urandom_range(0, 2)) step();
        end

        // OAM DMA from RAM page $02, even then odd start, then open-bus page
        for (int k = 0; k < 256; k++) begin
            issue(1'b0, 16'h0200 + 16'(k), 8'($urandom));
            step();
        end
        run_dma(8'h02, 1'b0, 513);
        step();
        run_dma(8'h02, 1'b1, 514);
        step();
        run_dma(8'h50, 1'b0, 513);
        step();
        issue(1'b1, 16'h2004, 8'h00);
        step();

        // Reset in the middle of a DMA
        issue(1'b0, 16'h4014, 8'h02);
        keep4 = ref_ram[16'h0200 + 63];
        step();
        ppu_wq.delete();
        waited = 0;
        while (ppu_wq.size() < 64 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check_value("t6_reach_idx40", 32'(ppu_wq.size()), 32'd64);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("t6_rdy", 32'(cpu_rdy), 32'd1);
        check_value("t6_ppu_we", 32'(ppu_we), 32'd0);
        check_value("t6_ack", 32'(cpu_ack), 32'd0);
        ref_ob      = 8'h00;
        ref_ppu[4]  = keep4;
        exp_ppu_we += 64;
        repeat (4) step();
        check_value("t6_no_more_wr", 32'(ppu_wq.size()), 32'd64);
        issue(1'b1, 16'h0805, 8'h00);
        step();
        issue(1'b1, 16'h4444, 8'h00);
        step();
        issue(1'b1, 16'h2004, 8'h00);
        step();
        step();

        check_value("cnt_ram_we", 32'(n_ram_we), 32'(exp_ram_we));
        check_value("cnt_ppu_we", 32'(n_ppu_we), 32'(exp_ppu_we));
        check_value("cnt_ppu_re", 32'(n_ppu_re), 32'(exp_ppu_re));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
